// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP instruction fetch path.
package yarp_pkg;

  localparam logic [31:0] YARP_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } yarp_imem_rsp_t;

endpackage

// File: rtl/yarp_imem_rsp_pipe.sv
// Delay line for fetch responses; DEPTH=0 is a plain wire.
// Data only advances with a valid response so the output holds across bubbles.
module yarp_imem_rsp_pipe
  import yarp_pkg::*;
#(
  parameter int          DEPTH      = 0,
  parameter logic [31:0] RESET_DATA = YARP_NOP_INSTR
) (
  input  logic           clk,
  input  logic           reset_n,
  input  yarp_imem_rsp_t rsp_in,
  output yarp_imem_rsp_t rsp_out
);

  if (DEPTH == 0) begin : g_pass
    assign rsp_out = rsp_in;
  end else begin : g_pipe
    yarp_imem_rsp_t stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= '{valid: 1'b0, err: 1'b0, data: RESET_DATA};
        end
      end else begin
        stage[0].valid <= rsp_in.valid;
        stage[0].err   <= rsp_in.err;
        if (rsp_in.valid) stage[0].data <= rsp_in.data;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i].valid <= stage[i-1].valid;
          stage[i].err   <= stage[i-1].err;
          if (stage[i-1].valid) stage[i].data <= stage[i-1].data;
        end
      end
    end

    assign rsp_out = stage[DEPTH-1];
  end

endmodule

// File: rtl/yarp_instr_mem_rsp.sv
// Instruction RAM answering fetch requests after READ_LATENCY cycles,
// with a loader write port and an error response for bad addresses.
module yarp_instr_mem_rsp
  import yarp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ERR_DATA     = YARP_NOP_INSTR,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_i,
  input  logic [31:0]   addr_i,
  output logic [31:0]   rd_data_o,
  output logic          rd_valid_o,
  output logic          rd_err_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("yarp_instr_mem_rsp: READ_LATENCY must be in 1..4");
  end

  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) * 32'd4;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [32:0]    offset;
  logic           addr_bad;
  logic [AW-1:0]  word_idx;
  yarp_imem_rsp_t rsp_s1;
  yarp_imem_rsp_t rsp_out;

  // 33-bit offset: bit 32 set means the address lies below BASE_ADDR.
  always_comb begin
    offset   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    addr_bad = (addr_i[1:0] != 2'b00) || offset[32] || (offset[31:0] >= SPAN);
    word_idx = offset[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset_n && ld_we_i) mem[ld_addr_i] <= ld_data_i;
  end

  // Stage 1 reads the RAM before any same-edge loader write lands (read-first).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_s1 <= '{valid: 1'b0, err: 1'b0, data: ERR_DATA};
    end else begin
      rsp_s1.valid <= req_i;
      rsp_s1.err   <= req_i && addr_bad;
      if (req_i) rsp_s1.data <= addr_bad ? ERR_DATA : mem[word_idx];
    end
  end

  yarp_imem_rsp_pipe #(
    .DEPTH      (READ_LATENCY - 1),
    .RESET_DATA (ERR_DATA)
  ) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .rsp_in  (rsp_s1),
    .rsp_out (rsp_out)
  );

  assign rd_valid_o = rsp_out.valid;
  assign rd_err_o   = rsp_out.err;
  assign rd_data_o  = rsp_out.data;

endmodule

// File: tb/tb_yarp_instr_mem_rsp.sv
// Directed bench: three instances (latency 1, 3, 4) share one stimulus stream.
module tb_yarp_instr_mem_rsp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_i;
  logic [31:0] addr_i;
  logic        ld_we_i;
  logic [9:0]  ld_addr_i;
  logic [31:0] ld_data_i;

  logic [31:0] d1, d3, d4;
  logic        v1, v3, v4, e1, e3, e4;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h0020_81B3;
  localparam logic [31:0] W3  = 32'h0000_0013;
  localparam logic [31:0] W5  = 32'h1111_1111;
  localparam logic [31:0] WL  = 32'hCAFE_F00D;
  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  yarp_instr_mem_rsp #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .addr_i(addr_i),
    .rd_data_o(d1), .rd_valid_o(v1), .rd_err_o(e1),
    .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i));

  yarp_instr_mem_rsp #(.READ_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .addr_i(addr_i),
    .rd_data_o(d3), .rd_valid_o(v3), .rd_err_o(e3),
    .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i));

  yarp_instr_mem_rsp #(.READ_LATENCY(4)) dut_l4 (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .addr_i(addr_i),
    .rd_data_o(d4), .rd_valid_o(v4), .rd_err_o(e4),
    .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i));

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic we, input logic [9:0] la,
                               input logic [31:0] ld);
    req_i     = req;
    addr_i    = addr;
    ld_we_i   = we;
    ld_addr_i = la;
    ld_data_i = ld;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic e,
                          input logic [31:0] d, input logic ev,
                          input logic ee, input logic [31:0] ed);
    checkOutput({tag, ".valid"}, {31'd0, v}, {31'd0, ev});
    checkOutput({tag, ".err"},   {31'd0, e}, {31'd0, ee});
    checkOutput({tag, ".data"},  d, ed);
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] prog [4];
  logic [31:0] load_data [6];
  logic [9:0]  load_addr [6];

  initial begin
    prog = '{W0, W1, W2, W3};
    load_data = '{W0, W1, W2, W3, W5, WL};
    load_addr = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd5, 10'd1023};

    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkRsp("reset_l1", v1, e1, d1, 1'b0, 1'b0, NOP);
    checkRsp("reset_l3", v3, e3, d3, 1'b0, 1'b0, NOP);
    checkRsp("reset_l4", v4, e4, d4, 1'b0, 1'b0, NOP);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, load_addr[i], load_data[i]);
      @(negedge clk);
    end
    idle(1);

    $display("[TB] back-to-back fetch, latency 1");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 10'd0, 32'h0);
      @(negedge clk);
      checkRsp($sformatf("b2b_%0d", i), v1, e1, d1, 1'b1, 1'b0, prog[i]);
    end
    idle(1);
    checkRsp("b2b_after", v1, e1, d1, 1'b0, 1'b0, W3);
    idle(5);

    $display("[TB] single fetch, latency 3");
    applyStimulus(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    checkOutput("lat3_c1.valid", {31'd0, v3}, 32'd0);
    @(negedge clk);
    checkOutput("lat3_c2.valid", {31'd0, v3}, 32'd0);
    @(negedge clk);
    checkRsp("lat3_c3", v3, e3, d3, 1'b1, 1'b0, W1);
    @(negedge clk);
    checkRsp("lat3_c4", v3, e3, d3, 1'b0, 1'b0, W1);
    @(negedge clk);
    checkRsp("lat3_c5", v3, e3, d3, 1'b0, 1'b0, W1);
    idle(4);

    $display("[TB] address errors and range boundary");
    applyStimulus(1'b1, 32'h0000_0002, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("err_misaligned", v1, e1, d1, 1'b1, 1'b1, NOP);
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("err_past_end", v1, e1, d1, 1'b1, 1'b1, NOP);
    applyStimulus(1'b1, 32'h0000_0FFC, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("last_word", v1, e1, d1, 1'b1, 1'b0, WL);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("err_top_addr", v1, e1, d1, 1'b1, 1'b1, NOP);
    idle(5);

    $display("[TB] read-first on same-cycle load");
    applyStimulus(1'b1, 32'h14, 1'b1, 10'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    checkRsp("rdfirst_old", v1, e1, d1, 1'b1, 1'b0, W5);
    applyStimulus(1'b1, 32'h14, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("rdfirst_new", v1, e1, d1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle(5);

    $display("[TB] reset mid-flight, latency 4");
    applyStimulus(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h8, 1'b1, 10'd0, 32'hBAD0_BAD0);
    reset_n = 1'b0;
    @(negedge clk);
    checkRsp("inreset_l1", v1, e1, d1, 1'b0, 1'b0, NOP);
    checkRsp("inreset_l4", v4, e4, d4, 1'b0, 1'b0, NOP);
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("flushed_%0d.valid", i), {31'd0, v4}, 32'd0);
    end
    applyStimulus(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    repeat (3) @(negedge clk);
    checkRsp("reread_w0", v4, e4, d4, 1'b1, 1'b0, W0);
    idle(5);

    $display("[TB] alternating requests and bubbles");
    applyStimulus(1'b1, 32'h0, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("alt_0", v1, e1, d1, 1'b1, 1'b0, W0);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("alt_1", v1, e1, d1, 1'b0, 1'b0, W0);
    applyStimulus(1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("alt_2", v1, e1, d1, 1'b1, 1'b0, W1);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    checkRsp("alt_3", v1, e1, d1, 1'b0, 1'b0, W1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yarp_instr_mem_rsp.md
Name: yarp_instr_mem_rsp

Overview:
- Responder end of the instruction fetch interface: a synchronous instruction RAM that answers fetch requests (req + 32-bit byte address) with read data.
- Sits between the fetch requester and the backing program storage.
- Provides configurable read latency, a response-valid strobe and an error flag for bad addresses.
- Includes a word-wide load port so a program loader can fill the RAM while reset_n is high.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be aligned to DEPTH_WORDS*4.
- READ_LATENCY, 1, cycles from request to response; legal range 1..4. Other values are a synthesis-time error.
- ERR_DATA, 32'h0000_0013, data returned on an error response (RV32I NOP).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_i  in  1  fetch request; one request per cycle when high
- addr_i  in  32  fetch byte address, sampled when req_i=1
- rd_data_o  out  32  instruction read data
- rd_valid_o  out  1  rd_data_o/rd_err_o valid this cycle
- rd_err_o  out  1  response is an error (misaligned or out of range)
- ld_we_i  in  1  loader write enable
- ld_addr_i  in  $clog2(DEPTH_WORDS)  loader word index
- ld_data_i  in  32  loader write data

Behaviour:
- Reset is asynchronous, active-low, on clk domain: reset_n and clk as already decided.
- Reset values: rd_valid_o=0, rd_err_o=0, rd_data_o=ERR_DATA. All pipeline stage valids are cleared.
- RAM contents are not reset; they persist across reset.

Request acceptance:
- The block never stalls; every cycle with req_i=1 is accepted.
- Word index = (addr_i - BASE_ADDR) >> 2.

Error classification, evaluated in the accept cycle:
- Misaligned: addr_i[1:0] != 0.
- Out of range: addr_i < BASE_ADDR, or addr_i >= BASE_ADDR + 4*DEPTH_WORDS. Comparison is 33-bit unsigned, so no wrap.
- Error response: rd_err_o=1 and rd_data_o=ERR_DATA. The RAM is not read.

Latency and pipelining:
- A request accepted in cycle N yields rd_valid_o=1 in cycle N+READ_LATENCY, registered output.
- Stage 1 is the RAM read register. Stages 2..READ_LATENCY form a valid/err/data shift pipe.
- Back-to-back requests produce back-to-back responses in request order. Up to READ_LATENCY responses are in flight.
- A cycle with req_i=0 produces a bubble: rd_valid_o=0, rd_err_o=0, and rd_data_o holds its previous value.

Loader port:
- ld_we_i=1 writes ld_data_i to ld_addr_i on the clk edge. Independent of req_i.
- Same-cycle read and write of the same word is read-first: the response carries the old data, and the new data is visible to requests accepted from the next cycle.

Reset mid-operation:
- All in-flight responses are discarded; no rd_valid_o pulse for them after reset deasserts.
- A ld_we_i asserted while reset_n=0 is ignored.

Boundary cases:
- Last word (BASE_ADDR+4*DEPTH_WORDS-4) is legal.
- Next word is an out-of-range error.
- Address 32'hFFFF_FFFC with BASE_ADDR=0 is an error, with no aliasing.

Decomposition:
- Shared package yarp_pkg:
  - constant YARP_NOP_INSTR = 32'h0000_0013, used as the ERR_DATA default;
  - typedef yarp_imem_rsp_t, a struct {valid, err, data[31:0]}.
- One sub-module, yarp_imem_rsp_pipe: parameterised shift pipe of yarp_imem_rsp_t with depth READ_LATENCY-1, asynchronous reset clearing valid/err. It passes through when depth is 0.
- The RAM array, address check and stage 1 stay in the top module.

Test Plan:
1. Load words 0..3 with 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. Then req at 0x0, 0x4, 0x8, 0xC on consecutive cycles, READ_LATENCY=1 -> rd_valid_o=1 on 4 consecutive cycles, data in order, rd_err_o=0.
2. READ_LATENCY=3, single req at 0x4 in cycle 10 -> rd_valid_o only in cycle 13, rd_data_o=32'h00A00113; data unchanged in cycles 14+.
3. req at 0x2, then at 0x1000 (DEPTH_WORDS=1024, BASE_ADDR=0) -> two responses, each rd_err_o=1 and rd_data_o=32'h00000013. Request at 0xFFC -> rd_err_o=0.
4. Same cycle: ld_we_i writes 32'hDEADBEEF to word 5 and req at 0x14 -> response returns the old word 5. Repeat req next cycle -> 32'hDEADBEEF.
5. READ_LATENCY=4, three back-to-back reqs, reset_n pulsed low for 1 cycle after the second -> no rd_valid_o for the discarded requests. Outputs equal reset values during reset. RAM contents are intact afterwards: re-reading word 0 returns 32'h00500093.
6. Alternating req_i 1/0 at 0x0, 0x4 -> rd_valid_o alternates 1/0, and rd_data_o holds during bubbles.
